mcycle: RTL and testbench
=========================

MCYCLE -- requirements
Module: mcycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port Start  input  1  operation request from ControlUnit M_Start; level-held by the initiator.
REQ-005 The block SHALL have port MCycleOp  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 The block SHALL have port Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 The block SHALL have port Operand2  input  WIDTH  multiplier or divisor.
REQ-008 The block SHALL have port Result1  output  WIDTH  product low word or quotient.
REQ-009 The block SHALL have port Result2  output  WIDTH  product high word or remainder.
REQ-010 The block SHALL have port Busy  output  1  high while an operation is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse back to ControlUnit.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-013 The FSM SHALL sample Start only in IDLE; Start=1 at a rising edge SHALL latch Operand1, Operand2 and MCycleOp, clear the step counter, and enter BUSY.
REQ-014 BUSY SHALL last exactly WIDTH cycles: one shift-add or restore-subtract step per cycle, with the counter running 0..WIDTH-1.
REQ-015 The edge that ends step WIDTH-1 SHALL load Result1/Result2 and enter DONE; done SHALL be high only in DONE, so done rises WIDTH+1 cycles after Start is accepted.
REQ-016 DONE SHALL return to IDLE unconditionally after one cycle; Start during DONE SHALL be ignored.
REQ-017 Start still high in the first IDLE cycle after DONE SHALL begin a new operation; the initiator must drop Start on done.
REQ-018 Busy SHALL be high in BUSY and DONE, and low in IDLE.
REQ-019 A multiply SHALL give the full 2*WIDTH-bit unsigned product: {Result2,Result1}.
REQ-020 A divide SHALL use restoring division: Result1 = floor(Operand1/Operand2), Result2 = Operand1 mod Operand2.
REQ-021 A divide by zero SHALL give Result1 = all ones and Result2 = Operand1, take the normal latency, and raise no error.
REQ-022 Result1/Result2 SHALL hold their last values from DONE until the next DONE; input changes during BUSY SHALL have no effect.

Reset
REQ-023 rst=1 SHALL force IDLE, counter=0, Result1=0, Result2=0, Busy=0 and done=0 immediately, independent of CLK.
REQ-024 rst asserted mid-BUSY SHALL abort the operation with no done pulse; the first operation after release SHALL behave as after power-up.

Configuration
REQ-025 Macro MCYCLE_DIV_EN defined SHALL compile in the divider datapath per REQ-020/021.
REQ-026 Without MCYCLE_DIV_EN, MCycleOp=1 SHALL go IDLE->DONE directly, giving one done pulse one cycle after acceptance with Result1=Result2=0.

Structure
REQ-027 Shared package mcycle_pkg SHALL hold the FSM state encoding, the MCycleOp encodings (OP_MUL=0, OP_DIV=1) and the default WIDTH.
REQ-028 One sub-module SHALL be used: mcycle_addsub, a combinational (WIDTH+1)-bit add/subtract step shared by the multiply and divide iterations.

Verification
REQ-029 Multiply: Operand1=7, Operand2=6, MCycleOp=0 -> done high exactly 33 cycles after acceptance, Result1=42, Result2=0.
REQ-030 Multiply: 0xFFFFFFFF x 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE.
REQ-031 Divide: 100 / 7 -> Result1=14, Result2=2; divide 5 / 0 -> Result1=0xFFFFFFFF, Result2=5.
REQ-032 Start held high through DONE -> exactly one done pulse; a new operation begins in the next IDLE cycle; dropping Start on done -> FSM stays in IDLE.
REQ-033 rst pulsed at BUSY step 10 -> Busy=0, done never asserted, results=0; a following 3 x 4 multiply -> Result1=12.
REQ-034 Build without MCYCLE_DIV_EN: divide 100 / 7 -> done one cycle after acceptance, Result1=Result2=0; multiply still correct.

Source files
------------

// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   DEFAULT_WIDTH : default operand/result width
//   OP_MUL/OP_DIV : MCycleOp encodings
//   state_t       : FSM state encoding (also visible on mcycle.state_dbg)
package mcycle_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mcycle_addsub.sv
// mcycle_addsub: combinational (WIDTH+1)-bit add/subtract step shared by the
// shift-add multiply and the restoring divide iterations.
//   a, b  : (WIDTH+1)-bit operands
//   sub   : 0 = a + b, 1 = a - b (two's complement: a + ~b + 1)
//   sum   : (WIDTH+1)-bit result
//   carry : carry out; on subtract, 1 means no borrow (a >= b)
module mcycle_addsub
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           carry
);

    logic [WIDTH:0] b_eff;

    assign b_eff        = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/mcycle.sv
// mcycle: multi-cycle unsigned multiplier / restoring divider.
//   CLK       : clock, rising edge
//   rst       : asynchronous active-high reset
//   Start     : operation request, level-held by the initiator
//   MCycleOp  : 0 = multiply, 1 = divide
//   Operand1  : multiplicand / dividend
//   Operand2  : multiplier / divisor
//   Result1   : product low word / quotient
//   Result2   : product high word / remainder
//   Busy      : high in BUSY and DONE
//   done      : one-cycle completion pulse (high only in DONE)
//   state_dbg : current FSM state (mcycle_pkg::state_t encoding)
// Build option: define MCYCLE_DIV_EN to include the divider datapath. Without
// it a divide request goes straight to DONE with zero results.
//
// Handshake: Start is sampled only in IDLE; a sampled Start=1 is the accept.
// The initiator keeps Start high until it sees done and must drop it then,
// otherwise the first IDLE cycle after DONE accepts a new operation.
module mcycle
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    // hi: product high / partial remainder; lo: product low / dividend being
    // shifted out while quotient bits shift in.
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_b;
    logic [WIDTH:0]   as_sum;
    logic             as_sub;
    logic             as_carry;
    logic             div_bypass;

`ifdef MCYCLE_DIV_EN
    logic op_q;
    assign div_bypass = 1'b0;
`else
    logic unused_carry;
    assign unused_carry = as_carry;
    assign div_bypass   = (MCycleOp == OP_DIV);
`endif

    assign state_dbg = state;

    mcycle_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (as_a),
        .b     (as_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    // Step inputs. Multiply adds the multiplicand only when the current
    // multiplier bit is set, so the shift below is the same either way.
    always_comb begin
        as_a   = {1'b0, hi};
        as_b   = lo[0] ? {1'b0, opb} : '0;
        as_sub = 1'b0;
`ifdef MCYCLE_DIV_EN
        if (op_q == OP_DIV) begin
            // Trial subtract of divisor from {remainder, next dividend bit}.
            as_a   = {hi, lo[WIDTH-1]};
            as_b   = {1'b0, opb};
            as_sub = 1'b1;
        end
`endif
    end

    always_comb begin
        hi_nxt = as_sum[WIDTH:1];
        lo_nxt = {as_sum[0], lo[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
        if (op_q == OP_DIV) begin
            // No borrow: keep the difference (always < divisor, fits WIDTH
            // bits) and shift in a 1. Divisor zero never borrows, giving an
            // all-ones quotient and the dividend as remainder.
            hi_nxt = as_carry ? as_sum[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_nxt = {lo[WIDTH-2:0], as_carry};
        end
`endif
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MCYCLE_DIV_EN
            op_q    <= OP_MUL;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (Start) begin
                        Busy <= 1'b1;
                        if (div_bypass) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            Result1 <= '0;
                            Result2 <= '0;
                        end else begin
                            state <= ST_BUSY;
                            count <= '0;
                            hi    <= '0;
                            lo    <= Operand1;
                            opb   <= Operand2;
`ifdef MCYCLE_DIV_EN
                            op_q  <= MCycleOp;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    hi    <= hi_nxt;
                    lo    <= lo_nxt;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        Result1 <= lo_nxt;
                        Result2 <= hi_nxt;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle.sv
// tb_mcycle: directed bench for mcycle. The driver pushes each operation's
// expected {done cycle, Result2, Result1} into exp_q at acceptance; a monitor
// pops and compares on every done pulse. Expectations for divides follow the
// MCYCLE_DIV_EN build option.
module tb_mcycle;
    import mcycle_pkg::*;

    localparam int W = 32;
`ifdef MCYCLE_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         CLK;
    logic         rst;
    logic         Start;
    logic         MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         done;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [95:0] exp_q[$];

    mcycle #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .Start     (Start),
        .MCycleOp  (MCycleOp),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Result1   (Result1),
        .Result2   (Result2),
        .Busy      (Busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [95:0] e;
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e[95:64]));
                chk("result1", 64'(Result1), 64'(e[31:0]));
                chk("result2", 64'(Result2), 64'(e[63:32]));
                chk("busy_in_done", 64'(Busy), 64'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (done !== 1'b1 && n < 100);
        if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_idle(input string name);
        chk(name, {61'd0, Busy, state_dbg}, {61'd0, 1'b0, 2'(ST_IDLE)});
    endtask

    // Issue one operation, scramble inputs while it runs, wait for done,
    // drop Start on done, then confirm the FSM is back in IDLE.
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r1, input logic [W-1:0] r2, input int lat);
        @(negedge CLK);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back({32'(cyc + lat - 1), r2, r1});
        chk("busy_after_accept", 64'(Busy), 64'd1);
        MCycleOp = 1'($urandom_range(0, 1));
        Operand1 = $urandom;
        Operand2 = $urandom;
        wait_done();
        Start = 1'b0;
        @(negedge CLK);
        check_idle("idle_after_done");
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lo_w, input logic [W-1:0] hi_w);
        do_op(OP_MUL, a, b, lo_w, hi_w, 33);
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r);
        if (DIV_ON) do_op(OP_DIV, a, b, q, r, 33);
        else        do_op(OP_DIV, a, b, '0, '0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        rst      = 1'b0;
        Start    = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result1", 64'(Result1), 64'd0);
        chk("reset_result2", 64'(Result2), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        repeat (2) @(negedge CLK);
        rst = 1'b0;

        // multiplies
        do_mul(32'd7, 32'd6, 32'd42, 32'd0);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        do_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
        do_mul(32'h8000_0000, 32'd3, 32'h8000_0000, 32'h0000_0001);
        do_mul(32'h1234_5678, 32'h10, 32'h2345_6780, 32'h0000_0001);
        do_mul(32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
        do_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0001);

        // divides
        do_div(32'd100, 32'd7, 32'd14, 32'd2);
        do_mul(32'd9, 32'd9, 32'd81, 32'd0);
        do_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        do_div(32'd7, 32'd100, 32'd0, 32'd7);
        do_div(32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
        do_mul(32'd11, 32'd13, 32'd143, 32'd0);

        // Start held through DONE: one pulse, then a second operation
        // accepted in the first IDLE cycle after DONE.
        @(negedge CLK);
        MCycleOp = OP_MUL;
        Operand1 = 32'd3;
        Operand2 = 32'd5;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        n0 = cyc;
        exp_q.push_back({32'(n0 + 32), 32'd0, 32'd15});
        exp_q.push_back({32'(n0 + 66), 32'd0, 32'd15});
        wait_done();
        wait_done();
        Start = 1'b0;
        @(negedge CLK);
        check_idle("idle_after_held_start");
        repeat (5) @(negedge CLK);
        check_idle("stays_idle");

        // Reset in the middle of BUSY (step 10).
        @(negedge CLK);
        MCycleOp = OP_MUL;
        Operand1 = 32'h0000_FFFF;
        Operand2 = 32'h0000_FFFF;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        repeat (10) @(posedge CLK);
        #2;
        chk("busy_before_abort", 64'(Busy), 64'd1);
        rst   = 1'b1;
        Start = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result1", 64'(Result1), 64'd0);
        chk("abort_result2", 64'(Result2), 64'd0);
        chk("abort_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge CLK);
        rst = 1'b0;
        repeat (40) @(negedge CLK);
        check_idle("idle_after_abort");
        do_mul(32'd3, 32'd4, 32'd12, 32'd0);

        repeat (5) @(negedge CLK);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
